// File: rtl/bundle_fetch_queue_if.sv
// Fetch/issue bus between the fetch queue, instruction memory and the lane decoders.
interface bundle_fetch_queue_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DEPTH     = 4
);
  logic [31:0]                  fetch_pc;
  logic [32*NUM_LANES-1:0]      inst_bundle;
  logic                         stall;
  logic                         branch_taken;
  logic [31:0]                  new_pc;
  logic                         issue_valid;
  logic [32*NUM_LANES-1:0]      issue_bundle;
  logic [31:0]                  issue_pc;
  logic                         squash;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    input  fetch_pc, issue_valid, issue_bundle, issue_pc, squash, occupancy,
    output inst_bundle, stall, branch_taken, new_pc
  );

  modport slave (
    output fetch_pc, issue_valid, issue_bundle, issue_pc, squash, occupancy,
    input  inst_bundle, stall, branch_taken, new_pc
  );
endinterface

// File: rtl/bundle_fetch_queue.sv
// Sequential VLIW fetch stage: owns the fetch PC and buffers fetched bundles in a
// DEPTH-entry FIFO whose head feeds the lane decoders; flushes on taken branches.
module bundle_fetch_queue #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  bundle_fetch_queue_if.slave bus
);
  localparam int unsigned BW    = 32 * NUM_LANES;
  localparam int unsigned BYTES = 4 * NUM_LANES;
  localparam int unsigned OFS   = $clog2(BYTES);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OW    = $clog2(DEPTH + 1);
  localparam logic [31:0]   STEP     = 32'(BYTES);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [BW-1:0] entry_bundle_q [DEPTH];
  logic [31:0]   entry_pc_q     [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          squash_q, squash_d;

  logic issue_valid;
  logic pop;
  logic push;
  logic wr_en;

  assign issue_valid = (occ_q != '0);
  assign pop         = issue_valid & ~bus.stall;
  // A full queue can still take a new bundle when the head leaves in the same cycle.
  assign push        = (occ_q != FULL_OCC) | pop;
  assign wr_en       = push & ~bus.branch_taken;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    fetch_pc_d = fetch_pc_q;
    squash_d   = 1'b0;
    if (bus.branch_taken) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      fetch_pc_d = {bus.new_pc[31:OFS], {OFS{1'b0}}};
      squash_d   = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        occ_d = occ_q + OW'(1);
      end else if (pop && !push) begin
        occ_d = occ_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      fetch_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_bundle_q[wr_ptr_q] <= bus.inst_bundle;
      entry_pc_q[wr_ptr_q]     <= fetch_pc_q;
    end
  end

  assign bus.fetch_pc     = fetch_pc_q;
  assign bus.issue_valid  = issue_valid;
  assign bus.issue_bundle = issue_valid ? entry_bundle_q[rd_ptr_q] : {NUM_LANES{32'h0000_0013}};
  assign bus.issue_pc     = issue_valid ? entry_pc_q[rd_ptr_q] : '0;
  assign bus.squash       = squash_q;
  assign bus.occupancy    = occ_q;
endmodule
